// File: rtl/sa_feeder_pkg.sv
// rtl/sa_feeder_pkg.sv - shared types and constants for the systolic-array weight feeder
package sa_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    // Bit positions inside the 3-bit op word, shared with the register file
    localparam int RELU_BIT   = 2;
    localparam int OP_SEL_BIT = 1;
    localparam int FLAT_BIT   = 0;

    // op_sel encodings
    localparam logic OP_MUL  = 1'b1;
    localparam logic OP_CONV = 1'b0;

    typedef logic [7:0] lane_t;

    // Limit a 4-bit geometry field to the physical array size
    function automatic logic [3:0] clamp_dim(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sa_skew_mux.sv
// rtl/sa_skew_mux.sv - diagonal wavefront lane selection of weight[c-j][j]
module sa_skew_mux
    import sa_feeder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] weights,
    input  logic [4:0]                         c,
    input  logic [3:0]                         wh,
    input  logic [3:0]                         ww,
    output logic [WIDTH*DATA_WIDTH-1:0]        lanes,
    output logic [WIDTH-1:0]                   mask
);

    // Lane j carries row c-j of column j while that row is inside the matrix;
    // wh is already clamped to HEIGHT so the row index stays in range.
    always_comb begin
        lanes = '0;
        mask  = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (j < int'(ww) && int'(c) >= j && (int'(c) - j) < int'(wh)) begin
                mask[j] = 1'b1;
                lanes[j*DATA_WIDTH +: DATA_WIDTH] =
                    weights[((int'(c) - j) * WIDTH + j) * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/sa_weight_feeder.sv
// rtl/sa_weight_feeder.sv - captures layer data and streams skewed weights into the systolic array
module sa_weight_feeder
    import sa_feeder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               weight_iv,
    input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] weight_id,
    input  logic                               bias_iv,
    input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] bias_id,
    input  logic                               layer_info_iv,
    input  logic [3:0]                         weight_height_id,
    input  logic [3:0]                         weight_width_id,
    input  logic [3:0]                         ifmap_height_id,
    input  logic [2:0]                         op_id,
    input  logic                               start_i,
    output logic                               sa_w_ov,
    output logic [WIDTH*DATA_WIDTH-1:0]        sa_w_od,
    output logic [WIDTH-1:0]                   sa_w_mask_od,
    output logic [WIDTH*DATA_WIDTH-1:0]        sa_bias_od,
    output logic [2:0]                         sa_op_od,
    input  logic                               sa_res_iv,
    output logic                               done_od,
    output logic                               err_od,
    output logic                               busy_od
);

    localparam int MW  = HEIGHT*WIDTH*DATA_WIDTH;
    localparam int LW  = WIDTH*DATA_WIDTH;
    localparam int RCW = $clog2(16);
    localparam int TW  = $clog2(TIMEOUT+1);

    state_t           state, state_n;
    logic [MW-1:0]    weight_q;
    logic [LW-1:0]    bias_q;          // only bias row 0 is ever consumed
    logic [3:0]       wh_q, ww_q, rh_q;
    logic [2:0]       op_q;
    logic             w_vld, b_vld, i_vld, clr_flags;
    logic [4:0]       c, c_n, c_last;
    logic [RCW-1:0]   res_cnt, res_cnt_n, res_inc;
    logic [TW-1:0]    idle_cnt, idle_cnt_n;
    logic             done_n, err_n, beat, go;
    logic             cap_w, cap_b, cap_i;
    logic [MW-1:0]    eff_w;
    logic [LW-1:0]    eff_b, bias_lanes, mux_lanes;
    logic [3:0]       eff_wh, eff_ww;
    logic [2:0]       eff_op;
    logic [WIDTH-1:0] mux_mask;
    logic             unused_bias;

    assign unused_bias = ^bias_id[MW-1:LW];

    // Same-cycle captures are visible to a start in that cycle
    assign cap_w  = (state == IDLE) && weight_iv;
    assign cap_b  = (state == IDLE) && bias_iv;
    assign cap_i  = (state == IDLE) && layer_info_iv;
    assign eff_w  = cap_w ? weight_id : weight_q;
    assign eff_b  = cap_b ? bias_id[LW-1:0] : bias_q;
    assign eff_wh = cap_i ? clamp_dim(weight_height_id, 4'(HEIGHT)) : wh_q;
    assign eff_ww = cap_i ? clamp_dim(weight_width_id, 4'(WIDTH)) : ww_q;
    assign eff_op = cap_i ? op_id : op_q;

    assign go = (state == IDLE) && start_i && (w_vld || weight_iv) && (b_vld || bias_iv)
                && (i_vld || layer_info_iv) && (eff_wh != 4'd0) && (eff_ww != 4'd0);

    assign c_last  = 5'(wh_q) + 5'(ww_q) - 5'd2;
    assign beat    = sa_res_iv && (res_cnt < rh_q);
    assign res_inc = res_cnt + RCW'(beat);
    assign busy_od = (state != IDLE);

    // MUL feeds bias row 0 lane-by-lane; CONV broadcasts the single scalar bias
    always_comb begin
        bias_lanes = '0;
        for (int j = 0; j < WIDTH; j++) begin
            bias_lanes[j*DATA_WIDTH +: DATA_WIDTH] = (eff_op[OP_SEL_BIT] == OP_MUL)
                ? eff_b[j*DATA_WIDTH +: DATA_WIDTH] : eff_b[DATA_WIDTH-1:0];
        end
    end

    // Lanes are computed for the next wavefront index so the outputs can be registered
    sa_skew_mux #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skew (
        .weights (eff_w),
        .c       (c_n),
        .wh      (eff_wh),
        .ww      (eff_ww),
        .lanes   (mux_lanes),
        .mask    (mux_mask)
    );

    // Next-state, wavefront index, result counting and timeout
    always_comb begin
        state_n    = state;
        c_n        = c;
        res_cnt_n  = res_cnt;
        idle_cnt_n = idle_cnt;
        done_n     = 1'b0;
        err_n      = 1'b0;
        clr_flags  = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_n    = STREAM;
                    c_n        = '0;
                    res_cnt_n  = '0;
                    idle_cnt_n = '0;
                end else if (start_i) begin
                    err_n = 1'b1;
                end
            end
            STREAM: begin
                res_cnt_n = res_inc;
                if (c == c_last) begin
                    if (res_inc >= rh_q) begin
                        state_n   = IDLE;
                        done_n    = 1'b1;
                        clr_flags = 1'b1;
                    end else begin
                        state_n    = WAIT_RES;
                        idle_cnt_n = '0;
                    end
                end else begin
                    c_n = c + 5'd1;
                end
            end
            WAIT_RES: begin
                res_cnt_n = res_inc;
                if (sa_res_iv) begin
                    idle_cnt_n = '0;
                    if (res_inc >= rh_q) begin
                        state_n   = IDLE;
                        done_n    = 1'b1;
                        clr_flags = 1'b1;
                    end
                end else if (idle_cnt == TW'(TIMEOUT-1)) begin
                    state_n   = IDLE;
                    err_n     = 1'b1;
                    clr_flags = 1'b1;
                end else begin
                    idle_cnt_n = idle_cnt + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            c        <= '0;
            res_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            c        <= c_n;
            res_cnt  <= res_cnt_n;
            idle_cnt <= idle_cnt_n;
        end
    end

    // Shadow registers and valid flags, written only while idle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            weight_q <= '0;
            bias_q   <= '0;
            wh_q     <= '0;
            ww_q     <= '0;
            rh_q     <= '0;
            op_q     <= '0;
            w_vld    <= 1'b0;
            b_vld    <= 1'b0;
            i_vld    <= 1'b0;
        end else if (clr_flags) begin
            w_vld <= 1'b0;
            b_vld <= 1'b0;
            i_vld <= 1'b0;
        end else if (state == IDLE) begin
            if (weight_iv) begin
                weight_q <= weight_id;
                w_vld    <= 1'b1;
            end
            if (bias_iv) begin
                bias_q <= bias_id[LW-1:0];
                b_vld  <= 1'b1;
            end
            if (layer_info_iv) begin
                wh_q  <= eff_wh;
                ww_q  <= eff_ww;
                rh_q  <= (ifmap_height_id == 4'd0) ? 4'd1 : ifmap_height_id;
                op_q  <= op_id;
                i_vld <= 1'b1;
            end
        end
    end

    // Registered array-facing outputs and completion pulses
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sa_w_ov      <= 1'b0;
            sa_w_od      <= '0;
            sa_w_mask_od <= '0;
            sa_bias_od   <= '0;
            sa_op_od     <= '0;
            done_od      <= 1'b0;
            err_od       <= 1'b0;
        end else begin
            sa_w_ov      <= (state_n == STREAM);
            sa_w_od      <= (state_n == STREAM) ? mux_lanes : '0;
            sa_w_mask_od <= (state_n == STREAM) ? mux_mask : '0;
            done_od      <= done_n;
            err_od       <= err_n;
            if (go) begin
                sa_bias_od <= bias_lanes;
                sa_op_od   <= eff_op;
            end else if (state_n == IDLE) begin
                sa_bias_od <= '0;
                sa_op_od   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sa_weight_feeder.sv
// tb/tb_sa_weight_feeder.sv - directed self-checking bench for sa_weight_feeder
module tb_sa_weight_feeder;
    import sa_feeder_pkg::*;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              nrst;
    logic              weight_iv, bias_iv, layer_info_iv, start_i, sa_res_iv;
    logic [H*W*DW-1:0] weight_id, bias_id;
    logic [3:0]        weight_height_id, weight_width_id, ifmap_height_id;
    logic [2:0]        op_id;
    logic              sa_w_ov, done_od, err_od, busy_od;
    logic [W*DW-1:0]   sa_w_od, sa_bias_od;
    logic [W-1:0]      sa_w_mask_od;
    logic [2:0]        sa_op_od;

    int checks = 0;
    int errors = 0;

    logic [H*W*DW-1:0] wvec, bvec;
    logic [2:0]        op_mul, op_conv;
    logic [63:0]       exp_l [4];
    logic [7:0]        exp_m [4];
    lane_t             conv_bias;
    int                n;
    logic              done_seen;

    always #5 clk = ~clk;

    sa_weight_feeder #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .weight_iv        (weight_iv),
        .weight_id        (weight_id),
        .bias_iv          (bias_iv),
        .bias_id          (bias_id),
        .layer_info_iv    (layer_info_iv),
        .weight_height_id (weight_height_id),
        .weight_width_id  (weight_width_id),
        .ifmap_height_id  (ifmap_height_id),
        .op_id            (op_id),
        .start_i          (start_i),
        .sa_w_ov          (sa_w_ov),
        .sa_w_od          (sa_w_od),
        .sa_w_mask_od     (sa_w_mask_od),
        .sa_bias_od       (sa_bias_od),
        .sa_op_od         (sa_op_od),
        .sa_res_iv        (sa_res_iv),
        .done_od          (done_od),
        .err_od           (err_od),
        .busy_od          (busy_od)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all(input logic [3:0] wh, input logic [3:0] ww, input logic [3:0] rh,
                            input logic [2:0] op, input logic [H*W*DW-1:0] b);
        weight_height_id = wh;
        weight_width_id  = ww;
        ifmap_height_id  = rh;
        op_id            = op;
        weight_id        = wvec;
        bias_id          = b;
        layer_info_iv    = 1'b1;
        weight_iv        = 1'b1;
        bias_iv          = 1'b1;
        tick();
        layer_info_iv    = 1'b0;
        weight_iv        = 1'b0;
        bias_iv          = 1'b0;
    endtask

    initial begin
        nrst = 1'b0;
        weight_iv = 1'b0; bias_iv = 1'b0; layer_info_iv = 1'b0; start_i = 1'b0; sa_res_iv = 1'b0;
        weight_id = '0; bias_id = '0;
        weight_height_id = '0; weight_width_id = '0; ifmap_height_id = '0; op_id = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                wvec[(r*W+c)*DW +: DW] = 8'(10*r + c);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                bvec[(r*W+c)*DW +: DW] = (r == 0) ? 8'(8'hB0 + c) : 8'hEE;
        op_mul  = '0; op_mul[OP_SEL_BIT]   = OP_MUL;
        op_conv = '0; op_conv[OP_SEL_BIT]  = OP_CONV;
        op_conv[RELU_BIT] = 1'b1;
        exp_l[0] = 64'h0;           exp_m[0] = 8'b001;
        exp_l[1] = 64'h010A;        exp_m[1] = 8'b011;
        exp_l[2] = 64'h020B00;      exp_m[2] = 8'b110;
        exp_l[3] = 64'h0C0000;      exp_m[3] = 8'b100;

        repeat (3) tick();
        chk("rst_ov",   64'(sa_w_ov), 64'd0);
        chk("rst_od",   64'(sa_w_od), 64'd0);
        chk("rst_mask", 64'(sa_w_mask_od), 64'd0);
        chk("rst_bias", 64'(sa_bias_od), 64'd0);
        chk("rst_op",   64'(sa_op_od), 64'd0);
        chk("rst_done", 64'(done_od), 64'd0);
        chk("rst_err",  64'(err_od), 64'd0);
        chk("rst_busy", 64'(busy_od), 64'd0);
        nrst = 1'b1;
        tick();

        // Geometry and weights but no bias: start must be refused
        weight_height_id = 4'd2; weight_width_id = 4'd3; ifmap_height_id = 4'd3; op_id = op_mul;
        weight_id = wvec; layer_info_iv = 1'b1; weight_iv = 1'b1;
        tick();
        layer_info_iv = 1'b0; weight_iv = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("nobias_err",  64'(err_od), 64'd1);
        chk("nobias_ov",   64'(sa_w_ov), 64'd0);
        chk("nobias_busy", 64'(busy_od), 64'd0);
        tick();
        chk("nobias_err_pulse", 64'(err_od), 64'd0);

        // Bias loaded, then weights and start in the same cycle
        bias_id = bvec; bias_iv = 1'b1;
        tick();
        bias_iv = 1'b0;
        weight_iv = 1'b1; start_i = 1'b1;
        tick();
        weight_iv = 1'b0; start_i = 1'b0;
        chk("mul_bias", 64'(sa_bias_od), 64'hB7B6B5B4B3B2B1B0);
        chk("mul_op",   64'(sa_op_od), 64'(op_mul));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wave%0d_ov", k),   64'(sa_w_ov), 64'd1);
            chk($sformatf("wave%0d_lane", k), 64'(sa_w_od), exp_l[k]);
            chk($sformatf("wave%0d_mask", k), 64'(sa_w_mask_od), 64'(exp_m[k]));
            tick();
        end
        chk("wave_end_ov",   64'(sa_w_ov), 64'd0);
        chk("wave_end_mask", 64'(sa_w_mask_od), 64'd0);
        chk("wave_end_od",   64'(sa_w_od), 64'd0);
        chk("wait_busy",     64'(busy_od), 64'd1);

        // Three result beats, five cycles apart
        for (int b = 0; b < 3; b++) begin
            sa_res_iv = 1'b1;
            tick();
            sa_res_iv = 1'b0;
            chk($sformatf("beat%0d_done", b), 64'(done_od), (b == 2) ? 64'd1 : 64'd0);
            chk($sformatf("beat%0d_err", b),  64'(err_od), 64'd0);
            if (b < 2) repeat (4) tick();
        end
        tick();
        chk("done_pulse", 64'(done_od), 64'd0);
        chk("done_busy",  64'(busy_od), 64'd0);
        chk("idle_bias",  64'(sa_bias_od), 64'd0);

        // CONV broadcast, rh=0 acts as one beat, beat arriving during STREAM
        conv_bias = 8'h7F;
        bvec[DW-1:0] = conv_bias;
        load_all(4'd1, 4'd1, 4'd0, op_conv, bvec);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("conv_ov",   64'(sa_w_ov), 64'd1);
        chk("conv_mask", 64'(sa_w_mask_od), 64'd1);
        chk("conv_bias", 64'(sa_bias_od), 64'h7F7F7F7F7F7F7F7F);
        chk("conv_op",   64'(sa_op_od), 64'(op_conv));
        sa_res_iv = 1'b1;
        tick();
        sa_res_iv = 1'b0;
        chk("early_done", 64'(done_od), 64'd1);
        chk("early_busy", 64'(busy_od), 64'd0);
        tick();

        // Timeout with no result beats
        load_all(4'd2, 4'd2, 4'd2, op_mul, bvec);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        chk("to_ov",   64'(sa_w_ov), 64'd0);
        chk("to_busy", 64'(busy_od), 64'd1);
        n = 0;
        done_seen = 1'b0;
        while (n < 40 && !err_od) begin
            tick();
            n++;
            if (done_od) done_seen = 1'b1;
        end
        chk("to_cycles",  64'(n), 64'd16);
        chk("to_no_done", 64'(done_seen), 64'd0);
        chk("to_idle",    64'(busy_od), 64'd0);
        tick();

        // Height clamp (15 -> 8) and asynchronous reset mid-stream
        load_all(4'd15, 4'd8, 4'd1, op_mul, bvec);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        chk("clamp_lane", 64'(sa_w_od), 64'h1B242D363F480000);
        chk("clamp_mask", 64'(sa_w_mask_od), 64'hFC);
        #1;
        nrst = 1'b0;
        #1;
        chk("arst_ov",   64'(sa_w_ov), 64'd0);
        chk("arst_od",   64'(sa_w_od), 64'd0);
        chk("arst_mask", 64'(sa_w_mask_od), 64'd0);
        chk("arst_bias", 64'(sa_bias_od), 64'd0);
        chk("arst_busy", 64'(busy_od), 64'd0);
        tick();
        nrst = 1'b1;
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("arst_lost_err", 64'(err_od), 64'd1);
        chk("arst_lost_ov",  64'(sa_w_ov), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_weight_feeder.md
Name: sa_weight_feeder

Overview:
Receiving end of the register-file-to-systolic-array interface. It captures the weight matrix, bias matrix and layer geometry broadcast by the register file. On a start pulse it streams the weights into the systolic array as a diagonally skewed wavefront and holds the bias lanes. It then counts result beats and returns a one-cycle done pulse, which the register file consumes to release its PC stall.

Parameters:
WIDTH, 8, systolic array columns and weight matrix max width
HEIGHT, 8, weight matrix max height
DATA_WIDTH, 8, element width in bits
TIMEOUT, 256, max idle cycles between result beats before abort

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
weight_iv  input  1  weight matrix valid pulse
weight_id  input  HEIGHT*WIDTH*DATA_WIDTH  weight matrix, [row][col][bit]
bias_iv  input  1  bias matrix valid pulse
bias_id  input  HEIGHT*WIDTH*DATA_WIDTH  bias matrix
layer_info_iv  input  1  geometry valid pulse
weight_height_id  input  4  weight rows (wh)
weight_width_id  input  4  weight cols (ww)
ifmap_height_id  input  4  expected result beats (rh)
op_id  input  3  {relu, op_sel (1=MUL, 0=CONV), flatten}
start_i  input  1  start pulse (send_sd)
sa_w_ov  output  1  weight wavefront valid
sa_w_od  output  WIDTH*DATA_WIDTH  per-column weight lane
sa_w_mask_od  output  WIDTH  per-lane valid
sa_bias_od  output  WIDTH*DATA_WIDTH  bias lanes, held while busy
sa_op_od  output  3  latched op
sa_res_iv  input  1  result beat from the systolic array
done_od  output  1  one-cycle completion pulse (received_SA_od)
err_od  output  1  one-cycle error pulse
busy_od  output  1  high outside IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; shadow registers, flags and counters 0.
- Capture is legal only in IDLE. Each iv pulse latches its data and sets the matching flag (w_vld, b_vld, i_vld). Pulses outside IDLE are ignored.
- Geometry: wh and ww are clamped to HEIGHT and WIDTH respectively; rh = 0 is treated as 1.
- start_i in IDLE:
  - Flags are evaluated as (flag | iv of the same cycle), so a capture in the same cycle counts.
  - If all three flags are set and wh != 0 and ww != 0: go to STREAM with c = 0.
  - Otherwise: err_od pulses the next cycle and the block stays in IDLE.
- start_i outside IDLE is ignored.
- STREAM:
  - Runs for c = 0 .. wh+ww-2, which is wh+ww-1 cycles. The first sa_w_ov is in the cycle after start_i is sampled (registered outputs).
  - Each cycle, lane j is valid iff j < ww and 0 <= c-j < wh; sa_w_od[j] = weight[c-j][j] when valid, else 0.
  - sa_w_ov is high for the whole window.
  - After c = wh+ww-2, go to WAIT_RES. sa_w_ov and mask drop to 0.
- sa_bias_od:
  - MUL: lane j = bias[0][j] for j < WIDTH.
  - CONV: bias[0][0] broadcast to every lane.
  - Latched at start and held until return to IDLE, then 0.
- WAIT_RES:
  - Counts sa_res_iv beats. On the rh-th beat, done_od pulses the next cycle, all three flags clear, and the state returns to IDLE.
  - sa_res_iv is also counted during STREAM, since the array may emit early. If the count is already rh when STREAM ends, done follows immediately.
  - Extra sa_res_iv in IDLE is ignored.
- Timeout: an idle counter resets on each beat. If it reaches TIMEOUT in WAIT_RES, err_od pulses, flags clear, and the state returns to IDLE with no done.
- done_od and err_od are never high in the same cycle.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs 0. Captured data is lost.
- Counter widths: c is 5 bits, sized for (HEIGHT+WIDTH-1) up to 15. The result count and timeout counters are sized by $clog2.

Decomposition:
- Package sa_feeder_pkg holds:
  - the state enum {IDLE, STREAM, WAIT_RES};
  - the op bit-position constants (RELU_BIT, OP_SEL_BIT, FLAT_BIT) and the MUL/CONV encodings, shared with the register file;
  - the lane_t element typedef.
- One sub-module, sa_skew_mux: combinational lane selection of weight[c-j][j] plus the mask, instantiated once.

Test Plan:
- wh=2, ww=3, weights w[r][c]=10r+c, then start → 4 STREAM cycles; lanes per cycle:
  - {0,-,-} mask 001;
  - {10,1,-} mask 011;
  - {-,11,2} mask 110;
  - {-,-,12} mask 100.
  Then sa_w_ov drops.
- Following the first case with rh=3: three sa_res_iv beats spaced 5 cycles apart → done_od is one cycle, exactly 1 cycle after the 3rd beat; busy_od is low afterwards.
- Start with bias never loaded → err_od pulse, no sa_w_ov. Weight and start in the same cycle, with bias and info already valid → stream proceeds.
- CONV op with bias[0][0]=0x7F → every sa_bias_od lane reads 0x7F during busy. MUL → lanes equal bias row 0.
- TIMEOUT=16 with no result beats after STREAM → err_od 16 cycles into WAIT_RES, no done, return to IDLE.
- nrst asserted mid-STREAM with wh=8, ww=8 → outputs 0 immediately. After release, a start without new loads → err_od.
